// File: rtl/lms_pkg.sv
// Shared geometry, types and the weight clamp for the LMS weight updater.
package lms_pkg;

  localparam int NUM_TAPS  = 64;
  localparam int SAMPLE_W  = 16;
  localparam int WEIGHT_W  = 10;
  localparam int TAP_IDX_W = $clog2(NUM_TAPS);
  localparam int PROD_W    = 2 * SAMPLE_W;
  localparam int SUM_W     = PROD_W + 1;
  localparam int WMAX      = (2 ** (WEIGHT_W - 1)) - 1;
  localparam int WMIN      = -(2 ** (WEIGHT_W - 1));

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [WEIGHT_W-1:0] weight_t;
  typedef logic [TAP_IDX_W-1:0]       tap_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} lms_state_t;

  function automatic weight_t sat_weight(input logic signed [SUM_W-1:0] s);
    if (s > SUM_W'(WMAX))      sat_weight = weight_t'(WMAX);
    else if (s < SUM_W'(WMIN)) sat_weight = weight_t'(WMIN);
    else                       sat_weight = s[WEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// Stage-2 datapath: scale the product, optionally leak the old weight, add, clamp.
// Leakage is enabled by defining LMS_LEAKAGE_EN.
module lms_tap_mac
  import lms_pkg::*;
#(
  parameter int STEP_SHIFT = 10,
  parameter int LEAK_SHIFT = 8
) (
  input  logic signed [PROD_W-1:0] prod,
  input  weight_t                  w_cur,
  output weight_t                  w_next
);

  if (STEP_SHIFT < 0 || STEP_SHIFT >= PROD_W) begin : g_step_chk
    $error("lms_tap_mac: STEP_SHIFT out of range");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT >= WEIGHT_W) begin : g_leak_chk
    $error("lms_tap_mac: LEAK_SHIFT out of range");
  end

  logic signed [PROD_W-1:0] delta;
  logic signed [SUM_W-1:0]  sum;

  assign delta = prod >>> STEP_SHIFT;

`ifdef LMS_LEAKAGE_EN
  weight_t leak;
  // Pulls every weight toward zero by 2^-LEAK_SHIFT per update.
  assign leak = w_cur >>> LEAK_SHIFT;
  assign sum  = SUM_W'(w_cur) - SUM_W'(leak) + SUM_W'(delta);
`else
  assign sum  = SUM_W'(w_cur) + SUM_W'(delta);
`endif

  assign w_next = sat_weight(sum);

endmodule

// File: rtl/lms_weight_updater.sv
// Sign-correct LMS weight updater for fir63; one tap per cycle, atomic commit.
// Optional leakage in the update term via LMS_LEAKAGE_EN.
module lms_weight_updater
  import lms_pkg::*;
#(
  parameter int STEP_SHIFT = 10,
  parameter int LEAK_SHIFT = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  input  sample_t                            error_in,
  input  logic [NUM_TAPS-1:0][SAMPLE_W-1:0]  sample,
  input  tap_idx_t                           offset,
  output logic [NUM_TAPS-1:0][WEIGHT_W-1:0]  weights_out,
  output logic                               busy_out,
  output logic                               done_out
);

  lms_state_t                        state;
  sample_t                           err_q;
  tap_idx_t                          off_q;
  logic [TAP_IDX_W:0]                cnt;
  logic                              issue;
  tap_idx_t                          x_idx;
  sample_t                           x_cur;

  logic                              s1_vld;
  tap_idx_t                          s1_idx;
  logic signed [PROD_W-1:0]          s1_prod;

  logic [NUM_TAPS-1:0][WEIGHT_W-1:0] work;
  weight_t                           wb_val;

  // Counter MSB marks that all taps have been issued for this update.
  assign issue    = (state == RUN) && !cnt[TAP_IDX_W];
  assign x_idx    = off_q - cnt[TAP_IDX_W-1:0];
  assign x_cur    = sample_t'(sample[x_idx]);
  assign busy_out = (state != IDLE);

  lms_tap_mac #(
    .STEP_SHIFT(STEP_SHIFT),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_mac (
    .prod  (s1_prod),
    .w_cur (weight_t'(work[s1_idx])),
    .w_next(wb_val)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      err_q       <= '0;
      off_q       <= '0;
      cnt         <= '0;
      s1_vld      <= 1'b0;
      s1_idx      <= '0;
      s1_prod     <= '0;
      work        <= '0;
      weights_out <= '0;
      done_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      s1_vld   <= issue;
      if (issue) begin
        s1_idx  <= cnt[TAP_IDX_W-1:0];
        s1_prod <= PROD_W'(err_q) * PROD_W'(x_cur);
        cnt     <= cnt + 1'b1;
      end
      if (s1_vld) work[s1_idx] <= wb_val;

      case (state)
        IDLE: begin
          if (start_in) begin
            state <= RUN;
            err_q <= error_in;
            off_q <= offset;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Last writeback lands on this edge, so COMMIT sees a complete set.
          if (s1_vld && s1_idx == tap_idx_t'(NUM_TAPS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          weights_out <= work;
          done_out    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_weight_updater.sv
// Scoreboard bench for lms_weight_updater: model pushes expected weights per start.
module tb_lms_weight_updater;
  import lms_pkg::*;

  localparam int STEP_SHIFT = 10;
  localparam int LEAK_SHIFT = 8;
  localparam int W_HI = 511;
  localparam int W_LO = -512;

  logic                              clk = 1'b0;
  logic                              rst = 1'b0;
  logic                              start = 1'b0;
  sample_t                           err = '0;
  logic [NUM_TAPS-1:0][SAMPLE_W-1:0] samp = '0;
  tap_idx_t                          off = '0;
  logic [NUM_TAPS-1:0][WEIGHT_W-1:0] wout;
  logic                              busy, done;

  lms_weight_updater #(.STEP_SHIFT(STEP_SHIFT), .LEAK_SHIFT(LEAK_SHIFT)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .error_in(err),
    .sample(samp), .offset(off), .weights_out(wout),
    .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, done_cnt = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [NUM_TAPS-1:0][WEIGHT_W-1:0] w;
    int                                due;
  } exp_t;
  exp_t sb[$];
  int   mw[NUM_TAPS];

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_w(longint s);
    if (s > W_HI) return W_HI;
    if (s < W_LO) return W_LO;
    return int'(s);
  endfunction

  // Reference update using the current err/off/samp (held constant over a run).
  task automatic model_run();
    for (int i = 0; i < NUM_TAPS; i++) begin
      tap_idx_t k;
      longint   d, s;
      k = off - tap_idx_t'(i);
      d = (longint'(err) * longint'(sample_t'(samp[k]))) >>> STEP_SHIFT;
`ifdef LMS_LEAKAGE_EN
      s = longint'(mw[i]) - longint'(mw[i] >>> LEAK_SHIFT) + d;
`else
      s = longint'(mw[i]) + d;
`endif
      mw[i] = sat_w(s);
    end
  endtask

  task automatic do_start(int e, int o);
    exp_t x;
    @(posedge clk); #1;
    err = sample_t'(e); off = tap_idx_t'(o); start = 1'b1;
    model_run();
    for (int i = 0; i < NUM_TAPS; i++) x.w[i] = WEIGHT_W'(mw[i]);
    @(posedge clk); #1;
    start = 1'b0;
    x.due = cyc + 66;
    sb.push_back(x);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle(string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin @(posedge clk); k++; end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  // Caller positions time; reset is asserted asynchronously mid-cycle.
  task automatic async_reset(string tag);
    #3 rst = 1'b1;
    #1;
    chk({tag, "_wout"}, |wout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    sb.delete();
    foreach (mw[i]) mw[i] = 0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic fill(int v);
    for (int i = 0; i < NUM_TAPS; i++) samp[i] = SAMPLE_W'(v);
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        x = sb.pop_front();
        chk("done_edge", cyc, x.due);
        chk("busy_at_done", busy, 0);
        for (int i = 0; i < NUM_TAPS; i++)
          chk($sformatf("w[%0d]", i), $signed(wout[i]), $signed(x.w[i]));
      end
    end
  end

  initial begin
    logic [NUM_TAPS-1:0][WEIGHT_W-1:0] prev;
    int d0;
    foreach (mw[i]) mw[i] = 0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wout", |wout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // Zero error leaves weights untouched
    fill(1000);
    do_start(0, 0);
    wait_idle("zero_err");
    chk("zero_err_w0", $signed(wout[0]), 0);

    // Basic positive step, then saturation
    fill(64);
    do_start(1024, 0);
    wait_idle("step1");
    chk("step1_w9", $signed(wout[9]), 64);
    for (int r = 0; r < 7; r++) begin
      do_start(1024, r * 5);
      wait_idle("step_rep");
    end
`ifdef LMS_LEAKAGE_EN
    chk("step_sat_w17", $signed(wout[17]), 508);
`else
    chk("step_sat_w17", $signed(wout[17]), 511);
`endif

    // Negative step toward the lower clamp, from a clean reset
    @(posedge clk); async_reset("rst_a");
    fill(64);
    for (int r = 0; r < 9; r++) begin
      do_start(-1024, 0);
      wait_idle("neg");
      if (r == 0) chk("neg1_w40", $signed(wout[40]), -64);
    end
`ifndef LMS_LEAKAGE_EN
    chk("neg_sat_w63", $signed(wout[63]), -512);
`endif

    // Offset wrap: offset 3, i=5 reads sample[62]
    @(posedge clk); async_reset("rst_b");
    fill(0);
    samp[62] = SAMPLE_W'(300);
    do_start(1024, 3);
    wait_idle("idx");
    chk("idx_w5", $signed(wout[5]), 300);
    chk("idx_w4", $signed(wout[4]), 0);
    samp[62] = SAMPLE_W'(1000);
    do_start(1024, 3);
    wait_idle("idx_sat");

    // Random patterns
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_TAPS; i++) samp[i] = SAMPLE_W'($urandom);
      do_start(int'(sample_t'($urandom)), int'($urandom_range(0, NUM_TAPS - 1)));
      wait_idle("rand");
    end

    // Handshake: starts at edges 10 and 66 ignored, error changes ignored
    fill(64);
    prev = wout;
    d0 = done_cnt;
    do_start(2048, 7);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; err = sample_t'(-3000);
    @(posedge clk); #1 start = 1'b0;
    repeat (55) @(posedge clk);
    #1;
    chk("hs_busy_e65", busy, 1);
    chk("hs_stable_e65", (wout == prev), 1);
    start = 1'b1; err = sample_t'(5000);
    @(posedge clk); #1 start = 1'b0;
    chk("hs_busy_e66", busy, 0);
    chk("hs_done_e66", done, 1);
    repeat (100) @(posedge clk);
    #1;
    chk("hs_one_done", done_cnt - d0, 1);
    chk("hs_sb_empty", sb.size(), 0);
    chk("hs_idle", busy, 0);

    // Reset at edge 30 of a run, then a clean update
    fill(256);
    do_start(1024, 0);
    repeat (30) @(posedge clk);
    async_reset("rst_mid");
    do_start(1024, 0);
    wait_idle("post_rst");
    chk("post_rst_w0", $signed(wout[0]), 256);
    do_start(0, 0);
    wait_idle("leak");
`ifdef LMS_LEAKAGE_EN
    chk("leak_w0", $signed(wout[0]), 255);
`else
    chk("noleak_w0", $signed(wout[0]), 256);
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
